yarvi_me_arb: RTL

Arbiter and sequencer for the `yarvi_me` load/store port. It shares the single memory-unit issue slot between the core pipeline (requester C) and an auxiliary debug/DMA master (requester A). It owns starvation control, tags the one-cycle-later response back to A, and replays A's loads rejected by `yarvi_me` as load-hit-store. It sits between the execute stage and `yarvi_me`. All issue outputs are combinational; `yarvi_me` registers them.

---
 rtl/yarvi_me_arb_if.sv | 31 +++
 rtl/yarvi_me_arb.sv | 56 +++++
 2 files changed

// File: rtl/yarvi_me_arb_if.sv
// yarvi_me_arb_if: core/aux request ports, issue bus and yarvi_me feedback for the memory-port arbiter
interface yarvi_me_arb_if;
  logic        c_valid, c_ready;
  logic [31:0] c_pc, c_addr, c_wdata;
  logic [4:0]  c_rd;
  logic        c_we, c_re;
  logic [2:0]  c_funct3;
  logic        a_valid, a_ready, a_we, a_rvalid, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [2:0]  a_funct3;
  logic        valid, writeenable, readenable;
  logic [31:0] pc, wb_val, writedata;
  logic [4:0]  wb_rd;
  logic [2:0]  funct3;
  logic [31:0] me_wb_val;
  logic        me_load_hit_store, me_exc_misaligned;
  modport master (
    output c_valid, c_pc, c_rd, c_addr, c_we, c_re, c_funct3, c_wdata,
           a_valid, a_addr, a_we, a_funct3, a_wdata,
           me_wb_val, me_load_hit_store, me_exc_misaligned,
    input  c_ready, a_ready, a_rvalid, a_rdata, a_err,
           valid, pc, wb_rd, wb_val, writeenable, readenable, funct3, writedata
  );
  modport slave (
    input  c_valid, c_pc, c_rd, c_addr, c_we, c_re, c_funct3, c_wdata,
           a_valid, a_addr, a_we, a_funct3, a_wdata,
           me_wb_val, me_load_hit_store, me_exc_misaligned,
    output c_ready, a_ready, a_rvalid, a_rdata, a_err,
           valid, pc, wb_rd, wb_val, writeenable, readenable, funct3, writedata
  );
endinterface

// File: rtl/yarvi_me_arb.sv
// yarvi_me_arb: shares the yarvi_me issue slot between core and aux, with starvation control and aux load-hit-store replay
module yarvi_me_arb #(
  parameter int AUX_MAX_WAIT = 8
) (
  input logic clock,
  input logic reset,
  yarvi_me_arb_if.slave bus
);
  localparam int WW = $clog2(AUX_MAX_WAIT + 1) > 0 ? $clog2(AUX_MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] MAXW = WW'(AUX_MAX_WAIT);
  typedef enum logic [1:0] {IDLE, A_PEND, REPLAY} state_t;
  state_t state;
  logic [WW-1:0] wait_cnt;
  logic [31:0] req_addr, req_wdata;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic a_grant, c_issue, replay, pend;
  assign a_grant = !reset && state == IDLE && bus.a_valid && (!bus.c_valid || wait_cnt == MAXW);
  // a pending aux load blocks the core so its possible replay cannot collide with a fresh store
  assign c_issue = !reset && bus.c_valid &&
                   ((state == IDLE && !a_grant) || (state == A_PEND && req_we));
  assign replay  = !reset && state == REPLAY;
  assign pend    = !reset && state == A_PEND && !bus.me_load_hit_store;
  assign bus.a_ready     = a_grant;
  assign bus.c_ready     = c_issue;
  assign bus.valid       = a_grant | c_issue | replay;
  assign bus.pc          = c_issue ? bus.c_pc : '0;
  assign bus.wb_rd       = c_issue ? bus.c_rd : '0;
  assign bus.wb_val      = a_grant ? bus.a_addr : replay ? req_addr : c_issue ? bus.c_addr : '0;
  assign bus.writeenable = a_grant ? bus.a_we : replay ? req_we : c_issue & bus.c_we;
  assign bus.readenable  = a_grant ? !bus.a_we : replay ? !req_we : c_issue & bus.c_re;
  assign bus.funct3      = a_grant ? bus.a_funct3 : replay ? req_funct3 : c_issue ? bus.c_funct3 : '0;
  assign bus.writedata   = a_grant ? bus.a_wdata : replay ? req_wdata : c_issue ? bus.c_wdata : '0;
  assign bus.a_err       = pend && bus.me_exc_misaligned;
  assign bus.a_rvalid    = pend && !bus.me_exc_misaligned && !req_we;
  assign bus.a_rdata     = bus.a_rvalid ? bus.me_wb_val : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      if (a_grant) begin
        state      <= A_PEND;
        wait_cnt   <= '0;
        req_addr   <= bus.a_addr;
        req_we     <= bus.a_we;
        req_funct3 <= bus.a_funct3;
        req_wdata  <= bus.a_wdata;
      end else if (bus.a_valid && wait_cnt != MAXW) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      state <= (state == A_PEND && bus.me_load_hit_store) ? REPLAY : (state == REPLAY ? A_PEND : IDLE);
    end
  end
endmodule
